// File: rtl/forth_alu_sequencer.sv
// Forth data-stack owner and stack-ALU sequencer (push / pop / ALU op, one command at a time).
// Optional FORTH_SEQ_OPCOUNT_EN adds o_OPCOUNT, a wrapping count of completed ALU commands.
`timescale 1ns/1ps
module forth_alu_sequencer #(
  parameter int DEPTH = 16,
  parameter int DW    = 16
) (
  input  logic                         c_CLOCK,
  input  logic                         c_RESET,
  input  logic                         i_CMD_VALID,
  output logic                         o_CMD_READY,
  input  logic [1:0]                   i_CMD,
  input  logic [3:0]                   i_ALUOP,
  input  logic [DW-1:0]                i_LITERAL,
  output logic [DW-1:0]                o_TOS,
  output logic [$clog2(DEPTH+1)-1:0]   o_DEPTH,
  output logic                         o_DONE,
  output logic                         o_ERR,
  output logic [1:0]                   o_ERRCODE,
`ifdef FORTH_SEQ_OPCOUNT_EN
  output logic [15:0]                  o_OPCOUNT,
`endif
  output logic [DW-1:0]                o_ALU_OP1,
  output logic [DW-1:0]                o_ALU_OP2,
  output logic [3:0]                   o_ALU_CTRL,
  input  logic [DW-1:0]                i_ALU_RESULT
);
  localparam int DPW = $clog2(DEPTH+1);
  localparam int AW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [DPW-1:0] ONE  = DPW'(1);
  localparam logic [DPW-1:0] TWO  = DPW'(2);
  localparam logic [DPW-1:0] FULL = DPW'(DEPTH);
  localparam logic [1:0] C_PUSH = 2'b00, C_POP = 2'b01, C_ALU = 2'b10;
  localparam logic [1:0] E_UNDER = 2'b01, E_OVER = 2'b10;

  typedef enum logic {IDLE, EXEC} state_t;

  state_t                   state, state_n;
  logic [DPW-1:0]           depth, depth_n, dm1, dm2;
  logic [AW-1:0]            ix1, ix2;
  logic [DEPTH-1:0][DW-1:0] stack;
  logic                     done_n, err_n, unary_q, unary_n, is_unary;
  logic [1:0]               errcode_n;
  logic [DW-1:0]            op1_n, op2_n;
  logic [3:0]               ctrl_n;
  logic                     wr_en;
  logic [AW-1:0]            wr_idx;
  logic [DW-1:0]            wr_data;

  assign dm1      = depth - ONE;
  assign dm2      = depth - TWO;
  assign ix1      = dm1[AW-1:0];
  assign ix2      = dm2[AW-1:0];
  assign is_unary = (i_ALUOP[3:2] == 2'b00);

  assign o_CMD_READY = (state == IDLE);
  assign o_DEPTH     = depth;
  assign o_TOS       = (depth == '0) ? '0 : stack[ix1];

  always_comb begin
    state_n   = state;
    depth_n   = depth;
    done_n    = 1'b0;
    err_n     = 1'b0;
    errcode_n = o_ERRCODE;
    op1_n     = o_ALU_OP1;
    op2_n     = o_ALU_OP2;
    ctrl_n    = o_ALU_CTRL;
    unary_n   = unary_q;
    wr_en     = 1'b0;
    wr_idx    = depth[AW-1:0];
    wr_data   = i_LITERAL;
    case (state)
      IDLE: if (i_CMD_VALID) begin
        case (i_CMD)
          C_PUSH: if (depth == FULL) begin
            err_n     = 1'b1;
            errcode_n = E_OVER;
          end else begin
            wr_en   = 1'b1;
            depth_n = depth + ONE;
            done_n  = 1'b1;
          end
          C_POP: if (depth == '0) begin
            err_n     = 1'b1;
            errcode_n = E_UNDER;
          end else begin
            depth_n = dm1;
            done_n  = 1'b1;
          end
          C_ALU: if ((is_unary && depth == '0) || (!is_unary && depth < TWO)) begin
            err_n     = 1'b1;
            errcode_n = E_UNDER;
          end else begin
            op1_n   = stack[ix1];
            op2_n   = is_unary ? '0 : stack[ix2];
            ctrl_n  = i_ALUOP;
            unary_n = is_unary;
            state_n = EXEC;
          end
          default: done_n = 1'b1;
        endcase
      end
      EXEC: begin
        // ALU result settled on the intervening negedge
        wr_en   = 1'b1;
        wr_data = i_ALU_RESULT;
        wr_idx  = unary_q ? ix1 : ix2;
        depth_n = unary_q ? depth : dm1;
        done_n  = 1'b1;
        state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge c_CLOCK or posedge c_RESET) begin
    if (c_RESET) begin
      state      <= IDLE;
      depth      <= '0;
      o_DONE     <= 1'b0;
      o_ERR      <= 1'b0;
      o_ERRCODE  <= 2'b00;
      o_ALU_OP1  <= '0;
      o_ALU_OP2  <= '0;
      o_ALU_CTRL <= 4'b0000;
      unary_q    <= 1'b0;
    end else begin
      state      <= state_n;
      depth      <= depth_n;
      o_DONE     <= done_n;
      o_ERR      <= err_n;
      o_ERRCODE  <= errcode_n;
      o_ALU_OP1  <= op1_n;
      o_ALU_OP2  <= op2_n;
      o_ALU_CTRL <= ctrl_n;
      unary_q    <= unary_n;
    end
  end

  // Contents are meaningless above depth, so the RAM needs no reset
  always_ff @(posedge c_CLOCK) begin
    if (wr_en) stack[wr_idx] <= wr_data;
  end

`ifdef FORTH_SEQ_OPCOUNT_EN
  always_ff @(posedge c_CLOCK or posedge c_RESET) begin
    if (c_RESET)             o_OPCOUNT <= '0;
    else if (state == EXEC)  o_OPCOUNT <= o_OPCOUNT + 16'd1;
  end
`endif

endmodule

// File: doc/forth_alu_sequencer.md
Name: forth_alu_sequencer

Overview:
- Owns the 16-bit Forth data stack and sequences the 16-operation stack ALU.
- Accepts one command at a time over a valid/ready handshake: push literal, pop, or ALU op.
- For an ALU op it fetches TOS/NOS, drives the ALU, captures the result and writes it back to the stack.
- Sits between the instruction decoder and the ALU; the ALU is clocked on the negedge of the same clock.

Parameters:
- DEPTH, 16, number of stack entries (>=2).
- DW, 16, data width; must match the ALU's 16-bit operands.

Ports:
- c_CLOCK  in  1  system clock; the ALU samples on its negedge.
- c_RESET  in  1  asynchronous, active-high reset.
- i_CMD_VALID  in  1  command valid.
- o_CMD_READY  out  1  sequencer can accept a command.
- i_CMD  in  2  00 PUSH, 01 POP, 10 ALU, 11 NOP.
- i_ALUOP  in  4  ALU control code for CMD=ALU.
- i_LITERAL  in  DW  value for PUSH.
- o_TOS  out  DW  current top of stack; 0 when empty.
- o_DEPTH  out  clog2(DEPTH+1)  current entry count.
- o_DONE  out  1  one-cycle pulse when a command completes without error.
- o_ERR  out  1  one-cycle pulse when a command is rejected.
- o_ERRCODE  out  2  01 underflow, 10 overflow; held until the next o_ERR.
- o_ALU_OP1  out  DW  operand to ALU i_OP1 (TOS).
- o_ALU_OP2  out  DW  operand to ALU i_OP2 (NOS).
- o_ALU_CTRL  out  4  to ALU f_aluctrl.
- i_ALU_RESULT  in  DW  from ALU o_RESULT.

Behaviour:
- Reset values (async on c_RESET high): state IDLE, depth 0, o_CMD_READY 1, o_DONE 0, o_ERR 0, o_ERRCODE 00, o_ALU_OP1/OP2 0, o_ALU_CTRL 0000, o_TOS 0. Stack RAM contents are don't-care.
- Reset mid-operation abandons an in-flight ALU op: no writeback and no o_DONE.
- States:
  - IDLE: o_CMD_READY=1.
  - EXEC: o_CMD_READY=0.
- Acceptance: a command is accepted on a posedge with i_CMD_VALID && o_CMD_READY.
- PUSH:
  - If depth==DEPTH: o_ERR with code 10; stack unchanged.
  - Otherwise write the literal at index depth and increment depth.
  - o_DONE pulses the cycle after acceptance. Stays in IDLE.
- POP:
  - If depth==0: o_ERR with code 01.
  - Otherwise decrement depth and pulse o_DONE. Stays in IDLE.
- NOP: o_DONE pulses; nothing else changes.
- ALU op classes:
  - Unary (i_ALUOP[3:2]==00) needs depth>=1.
  - Binary (all other codes) needs depth>=2.
  - Insufficient depth: o_ERR with code 01; no ALU issue; stay in IDLE.
- ALU op issue, at the acceptance edge:
  - Register o_ALU_OP1=stack[depth-1].
  - Register o_ALU_OP2=stack[depth-2] (binary only; 0 for unary).
  - Register o_ALU_CTRL=i_ALUOP.
  - Go to EXEC.
- ALU evaluation: the ALU evaluates on the following negedge.
- EXEC, next posedge:
  - Capture i_ALU_RESULT.
  - Unary: overwrite stack[depth-1]; depth unchanged.
  - Binary: write stack[depth-2] and decrement depth.
  - Pulse o_DONE and return to IDLE.
- Latency:
  - ALU command: 2 cycles from acceptance to o_DONE, 1 busy cycle.
  - PUSH/POP: o_DONE the cycle after acceptance, no busy cycle.
- Operand registers hold their last values after completion; the ALU is allowed to recompute them harmlessly.
- o_TOS is combinational from stack[depth-1] and reflects writes the cycle after they occur.
- Results wrap modulo 2^DW. The sequencer does no overflow checking of arithmetic.
- i_CMD_VALID while o_CMD_READY=0 is ignored; the requester must hold it.
- o_DONE and o_ERR are never asserted together.

Optional Feature:
- Macro: FORTH_SEQ_OPCOUNT_EN.
- Defined:
  - Adds output o_OPCOUNT [15:0], reset 0.
  - Increments by 1 on every o_DONE of an ALU command and wraps 0xFFFF->0.
  - Not incremented for PUSH, POP, NOP or errors.
- Undefined: the port and counter are absent; all other behaviour is identical.

Test Plan:
- Reset, then PUSH 7 and PUSH 3, then ALU 0101 -> o_DONE 2 cycles after accept; o_TOS=4; o_DEPTH=1.
- Depth 1 with TOS=0xFFFB, ALU 0001 (ABS) -> o_TOS=5; o_DEPTH=1; o_CMD_READY low exactly 1 cycle.
- Empty stack, POP -> o_ERR with o_ERRCODE=01; depth 0. Depth 1, ALU 0100 -> o_ERR code 01; stack unchanged; no ALU issue.
- DEPTH pushes of 0..15, then PUSH 99 -> o_ERR code 10; o_DEPTH=16; o_TOS=15.
- PUSH 5, PUSH 5, ALU 1110 -> o_TOS=0xFFFF. Then PUSH 0x8000, PUSH 0x8000, ALU 0100 -> o_TOS=0x0000 (wrap).
- Assert c_RESET during EXEC of ALU 0110 -> no o_DONE; o_DEPTH=0; o_CMD_READY=1; with FORTH_SEQ_OPCOUNT_EN, o_OPCOUNT=0.
